reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised integer register file with NRD combinational read ports and one write port.
//  Adds per-register busy scoreboard bits, set at issue and cleared at writeback.
//  Sits between decode/issue (read, mark busy) and writeback (write, release) in the core.
//  x0 hardwired to zero, never busy. Asynchronous reset clears all data and busy state.
// PARAMETERS
//  XLEN  32               data width in bits
//  NREGS 32               register count, power of two, >=2
//  NRD   2                number of read ports, >=1
//  AW    $clog2(NREGS)    address width (derived, not overridden)
// PORTS
//  clk       in   1         core clock, all state updates on posedge
//  rstn      in   1         reset; asynchronous and active-low
//  rd_addr   in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data   out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rd_busy   out  NRD       1 = addressed register has an outstanding producer
//  wr_en     in   1         writeback strobe
//  wr_addr   in   AW        writeback address
//  wr_data   in   XLEN      writeback data
//  iss_en    in   1         issue strobe: mark iss_addr busy
//  iss_addr  in   AW        destination register of issued instruction
//  flush     in   1         clear all busy bits (pipeline squash)
//  busy_cnt  out  AW+1      number of registers currently busy
// BEHAVIOUR
//  - Reset (rstn=0, async): all regs = 0, all busy = 0, busy_cnt = 0. rd_data/rd_busy follow state (0).
//  - Reset mid-operation: state cleared immediately. No posedge update while rstn=0.
//  - Reads: combinational, 0-cycle latency, one array read per port, ports independent.
//    rd_addr==0 -> rd_data=0, rd_busy=0.
//  - Write: posedge with wr_en=1 and wr_addr!=0 -> reg[wr_addr]<=wr_data, busy[wr_addr]<=0.
//    Writes to x0 are discarded.
//  - Issue: posedge with iss_en=1 and iss_addr!=0 -> busy[iss_addr]<=1. Issue to x0 ignored.
//  - Same-cycle wr_en and iss_en, same nonzero addr: data written, busy ends 1 (new producer wins).
//  - Issue to an already-busy reg: stays busy. Write to a non-busy reg: data updated, busy stays 0.
//  - Flush: posedge with flush=1 -> all busy<=0, overriding any same-cycle issue.
//    Same-cycle wr_en still updates data.
//  - busy_cnt: registered. Equals popcount(busy) after each edge. Range 0..NREGS-1; never counts x0.
//    Maintained incrementally: +1 on issue to a non-busy reg, -1 on write releasing a busy reg
//    (net 0 if both, same or different reg), forced 0 on flush.
//    Must equal popcount at all times (assert).
//  - No handshake: issue/writeback legality (at most one producer in flight per reg) is upstream's job.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding.
//    When wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr: rd_data[i]=wr_data, rd_busy[i]=0, same cycle.
//  Not defined: reads return pre-write array value and pre-write busy; new value visible the cycle after.
//  Sequential state update identical in both builds.
// TESTING
//  1. Reset: rstn=0 mid-run after writes -> every rd_data=0, rd_busy=0, busy_cnt=0 before next posedge.
//  2. x0: wr x0<=0xDEADBEEF, iss x0 -> rd x0=0, rd_busy=0, busy_cnt unchanged.
//  3. Scoreboard: iss x5 -> rd_busy(x5)=1, busy_cnt=1.
//     Next cycle wr x5<=0x1234 -> rd_busy=0, busy_cnt=0, rd_data(x5)=0x1234.
//  4. Collision: x7 busy, same edge wr x7<=0xA5A5A5A5 and iss x7 -> data=0xA5A5A5A5, busy(x7)=1, busy_cnt=1.
//  5. Flush: iss x1,x2,x3 (busy_cnt=3), then flush with iss x4 same edge -> all busy 0, busy_cnt=0.
//  6. Bypass: wr x9<=0xCAFEF00D, rd_addr0=x9 same cycle.
//     REGFILE_BYPASS_EN defined: 0xCAFEF00D. Not defined: old value, then 0xCAFEF00D next cycle.
//     Run with NRD=3, NREGS=16.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports, one write port and a per-register busy scoreboard.
// Optional build macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             wr_ok_s, iss_ok_s, inc_s, dec_s;

  assign wr_ok_s  = wr_en  && (wr_addr  != {AW{1'b0}});
  assign iss_ok_s = iss_en && (iss_addr != {AW{1'b0}});
  // A busy reg re-issued in the same cycle it is released still counts as a new producer.
  assign inc_s    = iss_ok_s && (!busy_q[iss_addr] || (wr_ok_s && (wr_addr == iss_addr)));
  assign dec_s    = wr_ok_s && busy_q[wr_addr];

  // Data array; x0 is never written so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {XLEN{1'b0}};
    end else if (wr_ok_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: release, then issue (new producer wins), then flush overrides all.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_s) busy_d[wr_addr] = 1'b0;
    else         busy_d = busy_d;
    if (iss_ok_s) busy_d[iss_addr] = 1'b1;
    else          busy_d = busy_d;
    if (flush) busy_d = {NREGS{1'b0}};
    else       busy_d = busy_d;
  end

  // Incremental busy counter next state.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (flush) busy_cnt_d = {(AW+1){1'b0}};
    else       busy_cnt_d = busy_cnt_q + (AW+1)'(inc_s) - (AW+1)'(dec_s);
  end

  // Scoreboard and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= {NREGS{1'b0}};
      busy_cnt_q <= {(AW+1){1'b0}};
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;
    assign addr_s = rd_addr[g*AW +: AW];

    // One array read per port, x0 forced to zero and never busy.
    always_comb begin
      data_s = regs_q[addr_s];
      busy_s = busy_q[addr_s];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok_s && (addr_s == wr_addr)) begin
        data_s = wr_data;
        busy_s = 1'b0;
      end else begin
        data_s = data_s;
        busy_s = busy_s;
      end
`endif
      if (addr_s == {AW{1'b0}}) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
      end else begin
        data_s = data_s;
        busy_s = busy_s;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = data_s;
    assign rd_busy[g]              = busy_s;
  end

  reg_file_sb_chk #(.NREGS(NREGS), .AW(AW)) u_chk (
    .clk      (clk),
    .rstn     (rstn),
    .busy     (busy_q),
    .busy_cnt (busy_cnt_q)
  );

endmodule

// Scoreboard invariants: counter tracks popcount, x0 never busy.
module reg_file_sb_chk #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic             clk,
  input logic             rstn,
  input logic [NREGS-1:0] busy,
  input logic [AW:0]      busy_cnt
);

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < NREGS; i++) c = c + (AW+1)'(v[i]);
    return c;
  endfunction

  a_cnt_pop: assert property (@(posedge clk) disable iff (!rstn) busy_cnt == popcount(busy))
    else $error("FAIL busy_cnt_popcount actual=%0d required=%0d", busy_cnt, popcount(busy));
  a_x0_idle: assert property (@(posedge clk) disable iff (!rstn) busy[0] == 1'b0)
    else $error("FAIL x0_busy actual=1 required=0");

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (NRD=3, NREGS=16): directed table, hand sequences, random vs model.
module tb_reg_file_sb;
  localparam int XLEN = 32, NREGS = 16, NRD = 3, AW = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en, iss_en, flush;
  logic [AW-1:0]       wr_addr, iss_addr;
  logic [XLEN-1:0]     wr_data;
  logic [AW:0]         busy_cnt;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_reg  [NREGS];
  bit          mdl_busy [NREGS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int mdl_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(mdl_busy[i]);
    return c;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NREGS; i++) begin
      mdl_reg[i]  = 32'h0;
      mdl_busy[i] = 1'b0;
    end
  endtask

  task automatic mdl_update(input bit we, input int wa, input logic [31:0] wd,
                            input bit ie, input int ia, input bit fl);
    if (we && wa != 0) begin
      mdl_reg[wa]  = wd;
      mdl_busy[wa] = 1'b0;
    end
    if (ie && ia != 0) mdl_busy[ia] = 1'b1;
    if (fl) for (int i = 0; i < NREGS; i++) mdl_busy[i] = 1'b0;
  endtask

  // Compare every read port against the model; fwd says a write is presented this cycle.
  task automatic chk_reads(input string tag, input bit fwd, input int wa, input logic [31:0] wd);
    for (int p = 0; p < NRD; p++) begin
      int a;
      logic [31:0] ed;
      logic eb;
      a  = int'(rd_addr[p*AW +: AW]);
      ed = mdl_reg[a];
      eb = mdl_busy[a];
      if (BYP && fwd && wa != 0 && wa == a) begin
        ed = wd;
        eb = 1'b0;
      end
      if (a == 0) begin
        ed = 32'h0;
        eb = 1'b0;
      end
      chk($sformatf("%s_data%0d", tag, p), rd_data[p*XLEN +: XLEN], ed);
      chk($sformatf("%s_busy%0d", tag, p), {31'h0, rd_busy[p]}, {31'h0, eb});
    end
  endtask

  // One clock cycle of strobes, checked before the edge and after it.
  task automatic cyc(input bit we, input int wa, input logic [31:0] wd,
                     input bit ie, input int ia, input bit fl);
    @(negedge clk);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia); flush = fl;
    #1;
    chk_reads("pre", we, wa, wd);
    @(posedge clk);
    mdl_update(we, wa, wd, ie, ia, fl);
    #1;
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    #1;
    chk("cnt", 32'(busy_cnt), 32'(mdl_cnt()));
    chk_reads("post", 1'b0, 0, 32'h0);
  endtask

  typedef struct {
    bit we; int wa; logic [31:0] wd; bit ie; int ia; bit fl;
    int ra; logic [31:0] ed; bit eb; int ec;
  } vec_t;
  vec_t tbl [15];

  initial begin
    tbl[0]  = '{0, 0, 32'h0,        1, 5,  0, 5,  32'h0,        1, 1};
    tbl[1]  = '{1, 5, 32'h00001234, 0, 0,  0, 5,  32'h00001234, 0, 0};
    tbl[2]  = '{1, 0, 32'hDEADBEEF, 1, 0,  0, 0,  32'h0,        0, 0};
    tbl[3]  = '{0, 0, 32'h0,        1, 7,  0, 7,  32'h0,        1, 1};
    tbl[4]  = '{1, 7, 32'hA5A5A5A5, 1, 7,  0, 7,  32'hA5A5A5A5, 1, 1};
    tbl[5]  = '{0, 0, 32'h0,        1, 7,  0, 7,  32'hA5A5A5A5, 1, 1};
    tbl[6]  = '{1, 7, 32'h11111111, 0, 0,  0, 7,  32'h11111111, 0, 0};
    tbl[7]  = '{0, 0, 32'h0,        1, 1,  0, 1,  32'h0,        1, 1};
    tbl[8]  = '{0, 0, 32'h0,        1, 2,  0, 2,  32'h0,        1, 2};
    tbl[9]  = '{0, 0, 32'h0,        1, 3,  0, 3,  32'h0,        1, 3};
    tbl[10] = '{0, 0, 32'h0,        1, 4,  1, 4,  32'h0,        0, 0};
    tbl[11] = '{1, 2, 32'h00000022, 0, 0,  0, 2,  32'h00000022, 0, 0};
    tbl[12] = '{1, 5, 32'h00000055, 1, 9,  0, 9,  32'h0,        1, 1};
    tbl[13] = '{1, 9, 32'h00000099, 1, 10, 0, 9,  32'h00000099, 0, 1};
    tbl[14] = '{1, 10, 32'h000000AA, 0, 0, 1, 10, 32'h000000AA, 0, 0};

    rstn = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    mdl_clear();
    rd_addr = {4'd15, 4'd7, 4'd1};
    #12;
    chk("reset_cnt", 32'(busy_cnt), 32'h0);
    chk_reads("reset", 1'b0, 0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      rd_addr = {4'd15, 4'd5, AW'(tbl[i].ra)};
      cyc(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].fl);
      chk($sformatf("tbl%0d_data", i), rd_data[XLEN-1:0], tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), {31'h0, rd_busy[0]}, {31'h0, tbl[i].eb});
      chk($sformatf("tbl%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].ec));
    end

    // Forwarding: x9 holds 0x99 and is made busy, then written while being read.
    rd_addr = {4'd2, 4'd10, 4'd9};
    cyc(0, 0, 32'h0, 1, 9, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hCAFEF00D;
    #1;
    chk("byp_same_data", rd_data[XLEN-1:0], BYP ? 32'hCAFEF00D : 32'h00000099);
    chk("byp_same_busy", {31'h0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
    @(posedge clk);
    mdl_update(1, 9, 32'hCAFEF00D, 0, 0, 0);
    #1;
    wr_en = 1'b0;
    #1;
    chk("byp_next_data", rd_data[XLEN-1:0], 32'hCAFEF00D);
    chk("byp_next_busy", {31'h0, rd_busy[0]}, 32'h0);
    chk("byp_next_cnt", 32'(busy_cnt), 32'h0);

    // Asynchronous reset in mid-cycle after writes and an issue.
    cyc(0, 0, 32'h0, 1, 3, 0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    mdl_clear();
    chk("async_rst_cnt", 32'(busy_cnt), 32'h0);
    chk_reads("async_rst", 1'b0, 0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 400; n++) begin
      int wa, ia;
      bit we, ie, fl;
      wa = int'($urandom_range(NREGS-1));
      ia = ($urandom_range(3) == 0) ? wa : int'($urandom_range(NREGS-1));
      we = ($urandom_range(2) != 0);
      ie = ($urandom_range(2) != 0);
      fl = ($urandom_range(19) == 0);
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(2) == 0) ? AW'(wa) : AW'($urandom_range(NREGS-1));
      cyc(we, wa, $urandom, ie, ia, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
